ascon128_decrypt_core: RTL and testbench

- Iterative Ascon-128 authenticated-decryption core, one permutation round per clock. Receive side of the Ascon-128 encrypt top.
- Takes key, nonce, one 64-bit associated-data word, the expected tag, and a stream of NBLK 64-bit ciphertext blocks. Emits a 64-bit plaintext block per ciphertext block, then a tag-check verdict.
- Shares round logic and constants with the encrypt path.

---
 rtl/ascon128_decrypt_core_pkg.sv | 25 ++
 rtl/ascon_round.sv | 49 ++++
 rtl/ascon128_decrypt_core.sv | 151 +++++++++++++++
 tb/tb_ascon128_decrypt_core.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon128_decrypt_core_pkg.sv
// Shared Ascon-128 constants, FSM encoding and round-constant helper used by
// the decrypt core and the common round function.
package ascon128_decrypt_core_pkg;

  localparam logic [63:0] ASCON_IV = 64'h80400c0600000000;
  localparam int unsigned PA       = 12;
  localparam int unsigned PB       = 6;
  localparam logic [63:0] PAD_WORD = 64'h8000000000000000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_AD    = 3'd2,
    ST_ADPAD = 3'd3,
    ST_MWAIT = 3'd4,
    ST_MPERM = 3'd5,
    ST_FINAL = 3'd6
  } state_t;

  // 0xf0 - idx*0x0f, idx counted across the full 12-round schedule
  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return {4'hf - idx, idx};
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon permutation round: constant addition, bitsliced 5-bit S-box and
// the per-word linear diffusion layer. Purely combinational.
module ascon_round
  import ascon128_decrypt_core_pkg::*;
(
  input  logic [319:0] s_in,
  input  logic [3:0]   rc_idx,
  output logic [319:0] s_out
);

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b2, b4;
  logic [63:0] c0, c1, c2, c3, c4;
  logic [63:0] d0, d1, d2, d3, d4;

  assign a0 = s_in[319:256];
  assign a1 = s_in[255:192];
  assign a2 = s_in[191:128] ^ {56'd0, round_const(rc_idx)};
  assign a3 = s_in[127:64];
  assign a4 = s_in[63:0];

  // S-box as the chi-like bitsliced network wrapped in the input/output XORs
  assign b0 = a0 ^ a4;
  assign b4 = a4 ^ a3;
  assign b2 = a2 ^ a1;

  assign c0 = b0 ^ (~a1 & b2);
  assign c1 = a1 ^ (~b2 & a3);
  assign c2 = b2 ^ (~a3 & b4);
  assign c3 = a3 ^ (~b4 & b0);
  assign c4 = b4 ^ (~b0 & a1);

  assign d0 = c0 ^ c4;
  assign d1 = c1 ^ c0;
  assign d2 = ~c2;
  assign d3 = c3 ^ c2;
  assign d4 = c4;

  assign s_out = {d0 ^ rotr(d0, 19) ^ rotr(d0, 28),
                  d1 ^ rotr(d1, 61) ^ rotr(d1, 39),
                  d2 ^ rotr(d2, 1)  ^ rotr(d2, 6),
                  d3 ^ rotr(d3, 10) ^ rotr(d3, 17),
                  d4 ^ rotr(d4, 7)  ^ rotr(d4, 41)};

endmodule

// File: rtl/ascon128_decrypt_core.sv
// Iterative Ascon-128 decryption: one round per clock, streams plaintext per
// ciphertext block and finishes with a constant-time tag verdict.
module ascon128_decrypt_core
  import ascon128_decrypt_core_pkg::*;
#(
  parameter int unsigned NBLK = 3,
  parameter logic [63:0] IV   = 64'h80400c0600000000
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  input  logic [127:0] SK,
  input  logic [127:0] N,
  input  logic [63:0]  A,
  input  logic [127:0] T_IN,
  input  logic         C_VALID,
  input  logic [63:0]  C,
  output logic         C_READY,
  output logic         P_VALID,
  output logic [63:0]  P,
  output logic         BUSY,
  output logic         DONE,
  output logic         AUTH_OK
);

  localparam logic [3:0] NBLK_W = 4'(NBLK);

  state_t       state;
  logic [319:0] s;
  logic [319:0] s_rnd;
  logic [127:0] key;
  logic [127:0] tag_ref;
  logic [63:0]  ad;
  logic [3:0]   rnd;
  logic [3:0]   blk;
  logic [3:0]   rc_idx;
  logic [3:0]   next_rnd;
  logic         is_pa;
  logic         last_rnd;

  assign is_pa    = (state == ST_INIT) || (state == ST_FINAL);
  assign rc_idx   = is_pa ? rnd : rnd + 4'(PA - PB);
  assign last_rnd = (rnd == (is_pa ? 4'(PA - 1) : 4'(PB - 1)));
  assign next_rnd = last_rnd ? '0 : rnd + 4'd1;

  assign C_READY = (state == ST_MWAIT);
  assign BUSY    = (state != ST_IDLE);

  ascon_round u_round (
    .s_in   (s),
    .rc_idx (rc_idx),
    .s_out  (s_rnd)
  );

  // Key/data injections that follow a permutation are folded into its last
  // round cycle so no extra cycle is spent between phases.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      s       <= '0;
      key     <= '0;
      tag_ref <= '0;
      ad      <= '0;
      rnd     <= '0;
      blk     <= '0;
      P       <= '0;
      P_VALID <= 1'b0;
      DONE    <= 1'b0;
      AUTH_OK <= 1'b0;
    end else begin
      P_VALID <= 1'b0;
      DONE    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            s       <= {IV, SK, N};
            key     <= SK;
            ad      <= A;
            tag_ref <= T_IN;
            AUTH_OK <= 1'b0;
            rnd     <= '0;
            blk     <= '0;
            state   <= ST_INIT;
          end
        end
        ST_INIT: begin
          rnd <= next_rnd;
          if (last_rnd) begin
            s     <= s_rnd ^ {ad, 128'd0, key};
            state <= ST_AD;
          end else begin
            s <= s_rnd;
          end
        end
        ST_AD: begin
          rnd <= next_rnd;
          if (last_rnd) begin
            s     <= s_rnd ^ {PAD_WORD, 256'd0};
            state <= ST_ADPAD;
          end else begin
            s <= s_rnd;
          end
        end
        ST_ADPAD: begin
          rnd <= next_rnd;
          if (last_rnd) begin
            s     <= s_rnd ^ 320'd1;
            state <= ST_MWAIT;
          end else begin
            s <= s_rnd;
          end
        end
        ST_MWAIT: begin
          if (C_VALID) begin
            P           <= s[319:256] ^ C;
            P_VALID     <= 1'b1;
            s[319:256]  <= C;
            blk         <= blk + 4'd1;
            rnd         <= '0;
            state       <= ST_MPERM;
          end
        end
        ST_MPERM: begin
          rnd <= next_rnd;
          if (last_rnd && (blk < NBLK_W)) begin
            s     <= s_rnd;
            state <= ST_MWAIT;
          end else if (last_rnd) begin
            // empty padded final block, then key into S1||S2 for finalisation
            s     <= s_rnd ^ {PAD_WORD, key, 128'd0};
            state <= ST_FINAL;
          end else begin
            s <= s_rnd;
          end
        end
        ST_FINAL: begin
          rnd <= next_rnd;
          s   <= s_rnd;
          if (last_rnd) begin
            // full-width XOR then reduce: no early exit on the first differing bit
            AUTH_OK <= ~|((s_rnd[127:0] ^ key) ^ tag_ref);
            DONE    <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon128_decrypt_core.sv
// Bench for ascon128_decrypt_core: table-driven Ascon model produces the
// ciphertext/tag to feed and the plaintext/verdict/timing to expect.
module tb_ascon128_decrypt_core;

  typedef logic [0:4][63:0] st_t;
  typedef logic [63:0] blk3_t [3];
  typedef struct { int cyc; logic [63:0] val; } pexp_t;

  localparam logic [63:0] IVC  = 64'h80400c0600000000;
  localparam logic [63:0] PADW = 64'h8000000000000000;
  localparam int          NB   = 3;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         START = 1'b0;
  logic [127:0] SK = '0;
  logic [127:0] N = '0;
  logic [63:0]  A = '0;
  logic [127:0] T_IN = '0;
  logic         C_VALID = 1'b0;
  logic [63:0]  C = '0;
  logic         C_READY;
  logic         P_VALID;
  logic [63:0]  P;
  logic         BUSY;
  logic         DONE;
  logic         AUTH_OK;

  ascon128_decrypt_core #(.NBLK(NB), .IV(IVC)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SK(SK), .N(N), .A(A),
    .T_IN(T_IN), .C_VALID(C_VALID), .C(C), .C_READY(C_READY),
    .P_VALID(P_VALID), .P(P), .BUSY(BUSY), .DONE(DONE), .AUTH_OK(AUTH_OK)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0] sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                            5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                            5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                            5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic st_t perm(input st_t s_i, input int nr);
    st_t s, t;
    logic [4:0] col, o;
    int idx;
    s = s_i;
    for (int r = 0; r < nr; r++) begin
      idx = 12 - nr + r;
      s[2] = s[2] ^ 64'(240 - 15 * idx);
      for (int b = 0; b < 64; b++) begin
        col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
        o = sbox[col];
        for (int w = 0; w < 5; w++) t[w][b] = o[4-w];
      end
      s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
      s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
      s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
      s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
      s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
    end
    return s;
  endfunction

  task automatic model(input logic [127:0] key, input logic [127:0] nonce, input logic [63:0] ad,
                       input blk3_t din, input bit dec, output blk3_t dout, output logic [127:0] tag);
    st_t s;
    s = {IVC, key, nonce};
    s = perm(s, 12);
    s[3] ^= key[127:64];
    s[4] ^= key[63:0];
    s[0] ^= ad;
    s = perm(s, 6);
    s[0] ^= PADW;
    s = perm(s, 6);
    s[4] ^= 64'd1;
    for (int j = 0; j < NB; j++) begin
      dout[j] = s[0] ^ din[j];
      s[0] = dec ? din[j] : dout[j];
      s = perm(s, 6);
    end
    s[0] ^= PADW;
    s[1] ^= key[127:64];
    s[2] ^= key[63:0];
    s = perm(s, 12);
    tag = {s[3] ^ key[127:64], s[4] ^ key[63:0]};
  endtask

  // ---------------- compare process ----------------
  pexp_t       pq[$];
  int          t0 = 0;
  bit          done_pending = 0;
  int          done_exp_cyc = 0;
  bit          auth_exp = 0;
  int          done_seen = 0;
  int          done_c = -1;
  logic [63:0] got_p [3];
  int          got_n = 0;

  always @(negedge CLK) begin : cmp
    int c;
    pexp_t e;
    c = cyc - t0;
    if (RST_N) begin
      if (P_VALID) begin
        check("pvalid_expected", {127'd0, P_VALID}, {127'd0, pq.size() != 0});
        if (pq.size() != 0) begin
          e = pq.pop_front();
          check("p_value", {64'd0, P}, {64'd0, e.val});
          check("p_cycle", 128'(c), 128'(e.cyc));
          if (got_n < NB) got_p[got_n] = P;
          got_n++;
        end
      end
      if (DONE) begin
        check("done_expected", {127'd0, DONE}, {127'd0, done_pending});
        if (done_pending) begin
          check("done_cycle", 128'(c), 128'(done_exp_cyc));
          check("auth_ok", {127'd0, AUTH_OK}, {127'd0, auth_exp});
          done_pending = 0;
        end
        done_seen++;
        done_c = c;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step(input bit stray);
    @(negedge CLK);
    if (stray && ((cyc - t0) == 5 || (cyc - t0) == 30)) begin
      START = 1'b1;
      SK    = {$urandom, $urandom, $urandom, $urandom};
      N     = {$urandom, $urandom, $urandom, $urandom};
      A     = {$urandom, $urandom};
      T_IN  = {$urandom, $urandom, $urandom, $urandom};
    end else begin
      START = 1'b0;
    end
  endtask

  task automatic run_msg(input logic [127:0] key, input logic [127:0] nonce, input logic [63:0] ad,
                         input blk3_t cin, input logic [127:0] tin, input int gap,
                         input bit stray, input int abort_at, output int dcyc);
    blk3_t pexp;
    logic [127:0] texp;
    int n;
    int last_k;
    dcyc = -1;
    last_k = 0;
    model(key, nonce, ad, cin, 1'b1, pexp, texp);
    pq.delete();
    got_n = 0;
    @(negedge CLK);
    SK = key; N = nonce; A = ad; T_IN = tin; C_VALID = 1'b0;
    START = 1'b1;
    t0 = cyc;
    auth_exp = (texp == tin);
    step(stray);
    check("auth_cleared_on_start", {127'd0, AUTH_OK}, 128'd0);
    for (int j = 0; j < NB; j++) begin
      n = 0;
      while (!C_READY) begin
        if (abort_at > 0 && (cyc - t0) >= abort_at) return;
        if (n > 100) begin
          check("ready_timeout", {127'd0, C_READY}, 128'd1);
          return;
        end
        n++;
        step(stray);
      end
      for (int g = 0; g < gap; g++) begin
        C_VALID = 1'b0;
        step(stray);
        check("ready_held", {127'd0, C_READY}, 128'd1);
      end
      C_VALID = 1'b1;
      C = cin[j];
      last_k = cyc - t0;
      pq.push_back('{last_k + 1, pexp[j]});
      step(stray);
      C = {$urandom, $urandom};
      C_VALID = (gap == 0);
    end
    C_VALID = 1'b0;
    done_exp_cyc = last_k + 19;
    done_pending = 1;
    n = 0;
    while (done_pending && n < 100) begin
      n++;
      step(1'b0);
    end
    check("done_arrived", {127'd0, done_pending}, 128'd0);
    done_pending = 0;
    check("all_p_seen", 128'(pq.size()), 128'd0);
    dcyc = done_c;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_c_ready"}, {127'd0, C_READY}, 128'd0);
    check({tag, "_p_valid"}, {127'd0, P_VALID}, 128'd0);
    check({tag, "_p"},       {64'd0, P},        128'd0);
    check({tag, "_busy"},    {127'd0, BUSY},    128'd0);
    check({tag, "_done"},    {127'd0, DONE},    128'd0);
    check({tag, "_auth_ok"}, {127'd0, AUTH_OK}, 128'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : main
    logic [127:0] key, nonce, tag, rtag;
    logic [63:0]  ad;
    blk3_t        pt, ct, rt, ct_bad;
    int           d, seen_before;

    key   = 128'h000102030405060708090a0b0c0d0e0f;
    nonce = 128'h000102030405060708090a0b0c0d0e0f;
    ad    = 64'h0001020304050607;
    pt    = '{64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333};

    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RST_N = 1'b1;

    // model self-consistency pinned against literal plaintexts
    model(key, nonce, ad, pt, 1'b0, ct, tag);
    model(key, nonce, ad, ct, 1'b1, rt, rtag);
    check("model_rt_p0", {64'd0, rt[0]}, {64'd0, 64'h1111111111111111});
    check("model_rt_p1", {64'd0, rt[1]}, {64'd0, 64'h2222222222222222});
    check("model_rt_p2", {64'd0, rt[2]}, {64'd0, 64'h3333333333333333});
    check("model_rt_tag", rtag, tag);
    check("model_ct_scrambled", {127'd0, ct[0] == pt[0]}, 128'd0);

    // round trip
    run_msg(key, nonce, ad, ct, tag, 0, 1'b0, 0, d);
    check("rt_done_cycle", 128'(d), 128'd58);
    check("rt_p0", {64'd0, got_p[0]}, {64'd0, 64'h1111111111111111});
    check("rt_p1", {64'd0, got_p[1]}, {64'd0, 64'h2222222222222222});
    check("rt_p2", {64'd0, got_p[2]}, {64'd0, 64'h3333333333333333});
    repeat (4) step(1'b0);
    check("rt_auth_held", {127'd0, AUTH_OK}, 128'd1);

    // tag tamper
    run_msg(key, nonce, ad, ct, tag ^ 128'd1, 0, 1'b0, 0, d);
    check("tt_done_cycle", 128'(d), 128'd58);
    check("tt_p2", {64'd0, got_p[2]}, {64'd0, 64'h3333333333333333});
    check("tt_auth", {127'd0, AUTH_OK}, 128'd0);

    // ciphertext tamper on the last block
    ct_bad = ct;
    ct_bad[2][63] = ~ct_bad[2][63];
    run_msg(key, nonce, ad, ct_bad, tag, 0, 1'b0, 0, d);
    check("ct_p0", {64'd0, got_p[0]}, {64'd0, 64'h1111111111111111});
    check("ct_p1", {64'd0, got_p[1]}, {64'd0, 64'h2222222222222222});
    check("ct_p2", {64'd0, got_p[2]}, {64'd0, 64'hb333333333333333});
    check("ct_auth", {127'd0, AUTH_OK}, 128'd0);

    // back-pressure
    run_msg(key, nonce, ad, ct, tag, 10, 1'b0, 0, d);
    check("bp_done_cycle", 128'(d), 128'd88);
    check("bp_p1", {64'd0, got_p[1]}, {64'd0, 64'h2222222222222222});
    check("bp_auth", {127'd0, AUTH_OK}, 128'd1);

    // stray START pulses while busy
    run_msg(key, nonce, ad, ct, tag, 0, 1'b1, 0, d);
    check("st_done_cycle", 128'(d), 128'd58);
    check("st_p2", {64'd0, got_p[2]}, {64'd0, 64'h3333333333333333});
    check("st_auth", {127'd0, AUTH_OK}, 128'd1);

    // reset mid-message
    seen_before = done_seen;
    run_msg(key, nonce, ad, ct, tag, 0, 1'b0, 35, d);
    check("abort_cycle", 128'(cyc - t0), 128'd35);
    check("abort_p_nonzero", {127'd0, P == 64'd0}, 128'd0);
    RST_N = 1'b0;
    #1;
    check_outputs_zero("abort");
    pq.delete();
    repeat (3) step(1'b0);
    RST_N = 1'b1;
    repeat (40) step(1'b0);
    check("abort_no_done", 128'(done_seen), 128'(seen_before));
    run_msg(key, nonce, ad, ct, tag, 0, 1'b0, 0, d);
    check("post_rst_done_cycle", 128'(d), 128'd58);
    check("post_rst_p0", {64'd0, got_p[0]}, {64'd0, 64'h1111111111111111});
    check("post_rst_auth", {127'd0, AUTH_OK}, 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
